// File: rtl/key_event_queue.sv
// Key event reader: decodes press/release words from the key device, queues
// 6-bit entries in a FIFO and returns one status-tagged word per CPU read.
module key_event_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kirq,
  input  logic [31:0] kin,
  input  logic        rd,
  input  logic        clr,
  output logic [31:0] out,
  output logic        rvalid,
  output logic        irq,
  output logic        empty,
  output logic        full
);

  localparam logic [AW:0] LEVEL_MAX = AW'(0) + (AW+1)'(DEPTH);

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level, next_level;
  logic [7:0]    drop_cnt;
  logic          err;
  logic [4:0]    last_key;

  logic          hdr_ok, is_press, is_rel, is_event, bad_word;
  logic          lvl_full, lvl_empty;
  logic          push, pop, drop;
  logic [5:0]    entry;

  // Decode. 8'h10 is the release code, so key 16 can never be pressed.
  always_comb begin
    hdr_ok   = (kin[31:24] == 8'd1) && (kin[23:8] == 16'd0);
    is_rel   = hdr_ok && (kin[7:0] == 8'h10);
    is_press = hdr_ok && (kin[7:5] == 3'd0) && (kin[4:0] != 5'd0) && !is_rel;
    is_event = is_press || is_rel;
    bad_word = kirq && !clr && !is_event;
    entry    = is_rel ? {1'b1, last_key} : {1'b0, kin[4:0]};
  end

  // Push/pop arbitration; clr suppresses both strobes.
  always_comb begin
    lvl_full   = (level == LEVEL_MAX);
    lvl_empty  = (level == '0);
    pop        = rd && !clr && !lvl_empty;
    push       = kirq && !clr && is_event && (!lvl_full || rd);
    drop       = kirq && !clr && is_event && lvl_full && !rd;
    next_level = level;
    if (push && !pop)      next_level = level + 1'b1;
    else if (pop && !push) next_level = level - 1'b1;
  end

  // NOTE: storage carries no reset; level/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      drop_cnt <= '0;
      err      <= 1'b0;
      last_key <= '0;
      out      <= '0;
      rvalid   <= 1'b0;
      irq      <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      drop_cnt <= '0;
      err      <= 1'b0;
      last_key <= '0;
      rvalid   <= 1'b0;
      irq      <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) begin
        // Read side sees the head before this cycle's push lands.
        if (pop) out <= {8'd2, 8'(level), drop_cnt, err, 1'b0, mem[rptr]};
        else     out <= {8'd0, 8'd0, drop_cnt, err, 1'b0, 6'd0};
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= next_level;
      empty <= (next_level == '0);
      irq   <= (next_level != '0);
      full  <= (next_level == LEVEL_MAX);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      if (bad_word) err <= 1'b1;
      if (kirq && is_press) last_key <= kin[4:0];
      else if (kirq && is_rel) last_key <= '0;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: directed stimulus pushes expected read
// words; a negedge monitor pops and compares on every rvalid.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        kirq, rd, clr;
  logic [31:0] kin;
  logic [31:0] out;
  logic        rvalid, irq, empty, full;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  key_event_queue #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .kirq(kirq), .kin(kin), .rd(rd), .clr(clr),
    .out(out), .rvalid(rvalid), .irq(irq), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else check("read_word", out, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kev(input logic [31:0] w);
    kirq = 1'b1;
    kin  = w;
    step();
    kirq = 1'b0;
  endtask

  task automatic rd_exp(input logic [31:0] exp);
    exp_q.push_back(exp);
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic flags(input string name, input logic e, input logic f);
    check({name, "_empty"}, 32'(empty), 32'(e));
    check({name, "_full"},  32'(full),  32'(f));
    check({name, "_irq"},   32'(irq),   32'(!e));
  endtask

  initial begin
    rst = 1'b1; kirq = 1'b0; rd = 1'b0; clr = 1'b0; kin = '0;
    step();
    check("rst_out", out, 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    flags("rst", 1'b1, 1'b0);
    rst = 1'b0;
    step();

    // Single press then read.
    kev(32'h01000003);
    flags("press1", 1'b0, 1'b0);
    rd_exp(32'h02010003);
    flags("pop1", 1'b1, 1'b0);
    step();

    // Press then release carries the pressed key.
    kev(32'h01000005);
    kev(32'h01000010);
    rd_exp(32'h02020005);
    rd_exp(32'h02010025);
    step();

    // Overflow: ninth press dropped, then drain plus one empty read.
    for (int i = 0; i < 9; i++) kev(32'h01000001);
    flags("full", 1'b0, 1'b1);
    for (int l = 8; l >= 1; l--) rd_exp({8'h02, 8'(l), 8'h01, 8'h01});
    rd_exp(32'h00000100);
    flags("drained", 1'b1, 1'b0);
    step();

    // Malformed header sets the error flag, only the valid press queues.
    pulse_clr();
    kev(32'h02000003);
    kev(32'h01000002);
    rd_exp(32'h02010082);
    flags("err_pop", 1'b1, 1'b0);
    step();

    // Full FIFO with simultaneous push and pop.
    pulse_clr();
    for (int k = 1; k <= 8; k++) kev(32'h01000000 | 32'(k));
    kirq = 1'b1; kin = 32'h01000009; rd = 1'b1;
    exp_q.push_back(32'h02080001);
    step();
    kirq = 1'b0; rd = 1'b0;
    flags("full_pp", 1'b0, 1'b1);
    for (int k = 2; k <= 9; k++) rd_exp({8'h02, 8'(10 - k), 8'h00, 8'(k)});
    step();

    // Empty FIFO with simultaneous push and pop.
    kirq = 1'b1; kin = 32'h0100000A; rd = 1'b1;
    exp_q.push_back(32'h00000000);
    step();
    kirq = 1'b0; rd = 1'b0;
    flags("empty_pp", 1'b0, 1'b0);
    rd_exp(32'h0201000A);
    step();

    // clr with kirq: queue, error and last_key wiped; out preserved.
    kev(32'h01000001);
    kev(32'h01000002);
    kev(32'h01000003);
    kev(32'hFF000000);
    clr = 1'b1; kirq = 1'b1; kin = 32'h01000007;
    step();
    clr = 1'b0; kirq = 1'b0;
    flags("clr", 1'b1, 1'b0);
    check("clr_out_held", out, 32'h0201000A);
    rd_exp(32'h00000000);
    kev(32'h01000010);
    rd_exp(32'h02010020);
    step();

    // Asynchronous reset mid-queue.
    kev(32'h01000005);
    kev(32'h01000006);
    #2 rst = 1'b1;
    #1;
    check("arst_out", out, 32'd0);
    check("arst_rvalid", 32'(rvalid), 32'd0);
    flags("arst", 1'b1, 1'b0);
    step();
    rst = 1'b0;
    rd_exp(32'h00000000);
    step();
    step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
